seg_display_mux: RTL and testbench
==================================

// Module: seg_display_mux
// PURPOSE
//  Downstream consumer of the stopwatch digit counters (minT|minO|secT|secO).
//  Time-multiplexes the four BCD digits onto one shared active-low 7-seg bus.
//  Blinks the field under adjustment (ADJ=1: SEL=0 seconds, SEL=1 minutes).
//  Drives board pins directly (an/seg/dp); all outputs are registered.
// PARAMETERS
//  SCAN_DIV   100000    clk cycles per digit slot (1 kHz/digit @ 100 MHz); >=2
//  BLINK_DIV  25000000  clk cycles per blink half-period (2 Hz blink @ 100 MHz); >=2
// PORTS
//  clk      in   1  single system clock; all logic on posedge clk
//  RESET_N  in   1  reset, asynchronous, active-low
//  minT     in   3  minutes tens digit (0-5 nominal)
//  minO     in   4  minutes ones digit (0-9 nominal)
//  secT     in   3  seconds tens digit (0-5 nominal)
//  secO     in   4  seconds ones digit (0-9 nominal)
//  ADJ      in   1  adjust mode; enables blinking of selected field
//  SEL      in   1  field select: 0 = seconds (digits 0,1), 1 = minutes (2,3)
//  an       out  4  digit anodes, active-low; an[0]=secO ... an[3]=minT
//  seg      out  7  segments, active-low, seg[6:0]={g,f,e,d,c,b,a}
//  dp       out  1  decimal point, active-low
// BEHAVIOUR
//  Reset (RESET_N=0, async): an=4'b1111, seg=7'b1111111, dp=1, scan_cnt=0,
//   digit_idx=0, blink_cnt=0, blink_ph=0. Outputs take these values immediately.
//  Scan: scan_cnt counts 0..SCAN_DIV-1 then wraps to 0; at the wrap cycle,
//   digit_idx advances 0->1->2->3->0 (2-bit wrap). Each slot = SCAN_DIV cycles.
//  Output regs load every cycle from current digit_idx and current inputs;
//   latency from input/digit_idx change to pins = 1 clk. an and seg always
//   change together (same register stage); never two anodes low at once.
//  Decode (value -> seg): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; 10-15 -> 1111111 (blank,
//   anode still enabled). 3-bit tens zero-extended; 6,7 decoded normally.
//  dp: low only in slot 2 (minO) as MM.SS separator; high elsewhere.
//  Blink: while ADJ=1, blink_cnt counts 0..BLINK_DIV-1 and at wrap toggles
//   blink_ph. While ADJ=0, blink_cnt and blink_ph held at 0 (synchronous clear),
//   so entering adjust always starts with a full visible half-period.
//  Blank condition: ADJ=1 & blink_ph=1 & slot in selected field (SEL=0: idx 0,1;
//   SEL=1: idx 2,3). Blanked slot: an=1111, seg=1111111, dp=1.
//  SEL change during adjust: takes effect next cycle; blink phase not reset.
//  ADJ falls while blanked: next cycle the digit is shown, blink_ph=0.
//  Scan wrap and blink wrap same cycle: both advance independently; no priority.
//  Inputs are sampled continuously; upstream counters share clk (no sync needed).
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=8)
//  1 Assert RESET_N=0 mid-scan -> same cycle an=1111, seg=1111111, dp=1; release
//    -> first slot is idx0 for 4 cycles.
//  2 min=12,sec=34, ADJ=0 -> an sequence 1110,1101,1011,0111 every 4 clks with
//    seg 0011001,0110000,0100100,1111001; dp=0 only with an=1011.
//  3 ADJ=1,SEL=0 -> slots 0,1 shown 8 clks, blanked (an=1111) next 8 clks,
//    repeat; slots 2,3 never blanked.
//  4 ADJ=1,SEL=1 -> slots 2,3 blink as in 3; drop ADJ while blanked -> digit
//    visible 1 clk later, blink_cnt=0.
//  5 secO=4'd12 -> slot 0 anode low, seg=1111111; secT=3'd7 -> seg=1111000.
//  6 Change minO 5->6 mid-slot 2 -> seg updates exactly 1 clk later, an unchanged.

Source files
------------

// File: rtl/seg_display_mux_if.sv
// Bundle between the stopwatch digit counters and the 7-segment display pins.
// The master drives digits and adjust controls; the slave drives the pins.
interface seg_display_mux_if;
    logic [2:0] minT;
    logic [3:0] minO;
    logic [2:0] secT;
    logic [3:0] secO;
    logic       ADJ;
    logic       SEL;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output minT, minO, secT, secO, ADJ, SEL,
        input  an, seg, dp
    );

    modport slave (
        input  minT, minO, secT, secO, ADJ, SEL,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexes four BCD stopwatch digits onto a shared active-low 7-seg bus,
// blinking the field under adjustment. All pin outputs are registered.
module seg_display_mux #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               RESET_N,
    seg_display_mux_if.slave   bus
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         digit_idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_ph_r;
    logic [3:0]         an_r;
    logic [6:0]         seg_r;
    logic               dp_r;

    logic               scan_wrap_s;
    logic               blink_wrap_s;
    logic [3:0]         digit_val_s;
    logic [3:0]         an_dig_s;
    logic               in_field_s;
    logic               blank_s;
    logic [3:0]         an_nxt_s;
    logic [6:0]         seg_nxt_s;
    logic               dp_nxt_s;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the segments.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
    assign blink_wrap_s = (blink_cnt_r == BLINK_LAST);

    // Scan timebase: digit slot advances when the slot counter wraps.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= 2'd0;
        end else if (scan_wrap_s) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= digit_idx_r + 2'd1;
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Blink timebase: held cleared outside adjust so each adjust starts visible.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_r <= '0;
            blink_ph_r  <= 1'b0;
        end else if (!bus.ADJ) begin
            blink_cnt_r <= '0;
            blink_ph_r  <= 1'b0;
        end else if (blink_wrap_s) begin
            blink_cnt_r <= '0;
            blink_ph_r  <= ~blink_ph_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Select the current slot's digit and anode, then apply field blanking.
    always_comb begin
        digit_val_s = 4'd0;
        an_dig_s    = 4'b1111;
        case (digit_idx_r)
            2'd0: begin
                digit_val_s = bus.secO;
                an_dig_s    = 4'b1110;
            end
            2'd1: begin
                digit_val_s = {1'b0, bus.secT};
                an_dig_s    = 4'b1101;
            end
            2'd2: begin
                digit_val_s = bus.minO;
                an_dig_s    = 4'b1011;
            end
            2'd3: begin
                digit_val_s = {1'b0, bus.minT};
                an_dig_s    = 4'b0111;
            end
            default: begin
                digit_val_s = 4'd0;
                an_dig_s    = 4'b1111;
            end
        endcase

        in_field_s = (digit_idx_r[1] == bus.SEL);
        blank_s    = bus.ADJ & blink_ph_r & in_field_s;

        if (blank_s) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'b1111111;
            dp_nxt_s  = 1'b1;
        end else begin
            an_nxt_s  = an_dig_s;
            seg_nxt_s = bcd_to_seg(digit_val_s);
            dp_nxt_s  = (digit_idx_r == 2'd2) ? 1'b0 : 1'b1;
        end
    end

    // Pin registers: an, seg and dp update together so anodes never overlap.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized bench for seg_display_mux against a cycle-count reference model.
module tb_seg_display_mux;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic clk;
    logic RESET_N;
    int   n_tests;
    int   n_fail;
    int   k_cyc;   // clock edges since reset release
    int   a_cyc;   // consecutive edges with ADJ sampled high
    logic [6:0] seg_tab [16];

    seg_display_mux_if bus ();

    seg_display_mux #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_idx();
        return (k_cyc / SCAN_DIV) % 4;
    endfunction

    function automatic logic model_blank();
        int  idx;
        logic ph;
        idx = model_idx();
        ph  = ((a_cyc / BLINK_DIV) % 2) == 1;
        return bus.ADJ && ph && ((bus.SEL == 1'b0) ? (idx < 2) : (idx >= 2));
    endfunction

    // Predict the pins after the next edge, clock once, then compare.
    task automatic step();
        int         idx;
        logic [3:0] val;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        idx = model_idx();
        case (idx)
            0:       val = bus.secO;
            1:       val = {1'b0, bus.secT};
            2:       val = bus.minO;
            default: val = {1'b0, bus.minT};
        endcase
        if (model_blank()) begin
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        end else begin
            e_an  = ~(4'b0001 << idx);
            e_seg = seg_tab[val];
            e_dp  = (idx == 2) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        k_cyc++;
        if (bus.ADJ) a_cyc++; else a_cyc = 0;
        #1;
        check_val("an",  {28'd0, bus.an},  {28'd0, e_an});
        check_val("seg", {25'd0, bus.seg}, {25'd0, e_seg});
        check_val("dp",  {31'd0, bus.dp},  {31'd0, e_dp});
    endtask

    task automatic check_reset_pins(input string tag);
        check_val({tag, "_an"},  {28'd0, bus.an},  32'h0000000F);
        check_val({tag, "_seg"}, {25'd0, bus.seg}, 32'h0000007F);
        check_val({tag, "_dp"},  {31'd0, bus.dp},  32'h00000001);
    endtask

    initial begin
        int found;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
        n_tests = 0; n_fail = 0; k_cyc = 0; a_cyc = 0;

        RESET_N = 1'b0;
        bus.minT = 3'd1; bus.minO = 4'd2; bus.secT = 3'd3; bus.secO = 4'd4;
        bus.ADJ = 1'b0; bus.SEL = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
        #1;
        check_reset_pins("rst_state");

        // Plain scan of 12:34
        for (int i = 0; i < 24; i++) step();

        // Async reset mid-slot takes effect without a clock edge
        #3;
        RESET_N = 1'b0;
        #1;
        check_reset_pins("async_rst");
        @(posedge clk);
        #1;
        check_reset_pins("rst_hold");
        @(negedge clk);
        RESET_N = 1'b1;
        k_cyc = 0; a_cyc = 0;
        @(posedge clk);
        #1;
        // First edge after release loads slot 0 (secO=4)
        k_cyc = 1;
        check_val("first_an",  {28'd0, bus.an},  32'h0000000E);
        check_val("first_seg", {25'd0, bus.seg}, 32'h00000019);
        for (int i = 0; i < 10; i++) step();

        // Adjust seconds, then minutes
        bus.ADJ = 1'b1; bus.SEL = 1'b0;
        for (int i = 0; i < 40; i++) step();
        bus.SEL = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // Drop ADJ while a minutes digit is blanked
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            if (model_blank()) found = 1; else step();
        end
        check_val("find_blank", found, 32'd1);
        bus.ADJ = 1'b0;
        step();
        bus.ADJ = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.ADJ = 1'b0;

        // Out-of-range digits: 12 blanks, tens 7 decodes normally
        bus.secO = 4'd12; bus.secT = 3'd7;
        for (int i = 0; i < 16; i++) step();

        // minO change mid slot 2
        bus.minO = 4'd5;
        found = 0;
        for (int i = 0; i < 32 && found == 0; i++) begin
            if (model_idx() == 2 && (k_cyc % SCAN_DIV) == 1) found = 1; else step();
        end
        check_val("find_slot2", found, 32'd1);
        step();
        bus.minO = 4'd6;
        for (int i = 0; i < 4; i++) step();

        // Randomized run
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) bus.ADJ = ~bus.ADJ;
            if ($urandom_range(0, 19) == 0) bus.SEL = ~bus.SEL;
            if ($urandom_range(0, 4) == 0) begin
                bus.minT = 3'($urandom_range(0, 7));
                bus.minO = 4'($urandom_range(0, 15));
                bus.secT = 3'($urandom_range(0, 7));
                bus.secO = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
